// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder: frame FSM states,
// prefix/ignore scancodes and the bit positions of the ps2_key event bus.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        PROCESS
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL    = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    localparam logic [7:0] PS2_IGN_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_IGN_ACK    = 8'hFA;
    localparam logic [7:0] PS2_IGN_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_IGN_RESEND = 8'hFE;
    localparam logic [7:0] PS2_IGN_ERR0   = 8'h00;
    localparam logic [7:0] PS2_IGN_ERRF   = 8'hFF;

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

    // Device responses and buffer-overrun codes that must never reach the key bus.
    function automatic logic ps2_is_ignored(input logic [7:0] code);
        return (code == PS2_IGN_BAT_OK) || (code == PS2_IGN_ACK) ||
               (code == PS2_IGN_ECHO)   || (code == PS2_IGN_RESEND) ||
               (code == PS2_IGN_ERR0)   || (code == PS2_IGN_ERRF);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length filter: the output only follows
// the synchronised line after FILTER_LEN consecutive samples that differ from it.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic line_o
);

    localparam logic [7:0] RUN_LAST = 8'(FILTER_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       out_q;
    logic [7:0] run_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            out_q   <= 1'b1;
            run_q   <= 8'd0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            // run_q counts consecutive samples disagreeing with the current output
            if (sync2_q == out_q) begin
                run_q <= 8'd0;
            end else if (run_q == RUN_LAST) begin
                out_q <= sync2_q;
                run_q <= 8'd0;
            end else begin
                run_q <= run_q + 8'd1;
            end
        end
    end

    assign line_o = out_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host frame receiver folding E0/F0/E1 prefixes into ps2_key events.
// Build option: define PS2_PARITY_CHECK_EN to discard frames failing odd parity.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err
);

    localparam int             TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_f;
    logic          data_f;
    logic          clk_prev_q;
    logic          fall;

    ps2_state_e    state_q;
    logic [7:0]    shreg_q;
    logic          parity_q;
    logic [2:0]    bitcnt_q;
    logic          ext_q;
    logic          rel_q;
    logic [2:0]    skip_q;
    logic [TW-1:0] tmo_q;
    logic [10:0]   key_q;
    logic          err_q;
    logic [10:0]   key_d;
    logic          frame_ok;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_i  (clk_sys),
        .rst_ni (reset),
        .line_i (ps2_clk),
        .line_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_i  (clk_sys),
        .rst_ni (reset),
        .line_i (ps2_data),
        .line_o (data_f)
    );

    assign fall  = clk_prev_q & ~clk_f;
    assign key_d = {~key_q[KEY_TOGGLE], ~rel_q, ext_q, shreg_q};

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = ^{parity_q, shreg_q};
`else
    // The parity bit is kept for observability only; it has no effect on decoding.
    logic unused_parity;
    assign unused_parity = parity_q;
    assign frame_ok      = 1'b1;
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            shreg_q    <= 8'd0;
            parity_q   <= 1'b0;
            bitcnt_q   <= 3'd0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            skip_q     <= 3'd0;
            tmo_q      <= '0;
            key_q      <= 11'd0;
            err_q      <= 1'b0;
        end else begin
            clk_prev_q <= clk_f;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (fall && !data_f) begin
                        state_q  <= DATA;
                        bitcnt_q <= 3'd0;
                    end
                end
                PROCESS: begin
                    state_q <= IDLE;
                    tmo_q   <= '0;
                    if (skip_q != 3'd0) begin
                        skip_q <= skip_q - 3'd1;
                    end else if (shreg_q == PS2_PFX_PAUSE) begin
                        skip_q <= PS2_PAUSE_SKIP;
                    end else if (shreg_q == PS2_PFX_EXT) begin
                        ext_q <= 1'b1;
                    end else if (shreg_q == PS2_PFX_REL) begin
                        rel_q <= 1'b1;
                    end else if (ps2_is_ignored(shreg_q)) begin
                        ext_q <= 1'b0;
                        rel_q <= 1'b0;
                    end else begin
                        key_q <= key_d;
                        ext_q <= 1'b0;
                        rel_q <= 1'b0;
                    end
                end
                default: begin
                    // An edge beats a simultaneous timeout terminal count.
                    if (fall) begin
                        tmo_q <= '0;
                        case (state_q)
                            DATA: begin
                                shreg_q  <= {data_f, shreg_q[7:1]};
                                bitcnt_q <= bitcnt_q + 3'd1;
                                if (bitcnt_q == 3'd7) begin
                                    state_q <= PARITY;
                                end
                            end
                            PARITY: begin
                                parity_q <= data_f;
                                state_q  <= STOP;
                            end
                            STOP: begin
                                if (data_f && frame_ok) begin
                                    state_q <= PROCESS;
                                end else begin
                                    state_q <= IDLE;
                                    err_q   <= 1'b1;
                                    ext_q   <= 1'b0;
                                    rel_q   <= 1'b0;
                                    skip_q  <= 3'd0;
                                end
                            end
                            default: state_q <= IDLE;
                        endcase
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        tmo_q   <= '0;
                        ext_q   <= 1'b0;
                        rel_q   <= 1'b0;
                        skip_q  <= 3'd0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
            endcase
        end
    end

    assign ps2_key = key_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames push expected events,
// an independent monitor pops them on every ps2_key change or err pulse.
module tb_ps2_key_decoder;

    localparam int FLEN = 8;
    localparam int TMO  = 200;
    localparam int H    = 20;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        err;

    typedef struct packed {
        logic        is_err;
        logic [10:0] key;
    } exp_t;

    exp_t        expq[$];
    int          total    = 0;
    int          bad      = 0;
    logic        mon_en   = 1'b0;
    logic        err_prev = 1'b0;
    logic [10:0] last_key = 11'd0;

    ps2_key_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .err      (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Data changes while the clock is high; optional short low glitch on the clock.
    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(4);
            ps2_clk = 1'b0;
            wait_cyc(FLEN - 1);
            ps2_clk = 1'b1;
            wait_cyc(H - 4 - (FLEN - 1));
        end else begin
            wait_cyc(H);
        end
        ps2_clk = 1'b0;
        wait_cyc(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit = 1'b1,
                              input logic par_flip = 1'b0, input int glitch_bit = -1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i);
        send_bit(~^b ^ par_flip, 1'b0);
        send_bit(stop_bit, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(H);
    endtask

    task automatic push_key(input logic [10:0] k);
        expq.push_back('{is_err: 1'b0, key: k});
    endtask

    task automatic push_err();
        expq.push_back('{is_err: 1'b1, key: 11'd0});
    endtask

    task automatic check_event(input logic is_err, input logic [10:0] k);
        exp_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got err=%b key=%h required=none", is_err, k);
        end else begin
            e = expq.pop_front();
            if (e.is_err !== is_err || (!is_err && e.key !== k)) begin
                bad++;
                $display("FAIL event got err=%b key=%h required err=%b key=%h",
                         is_err, k, e.is_err, e.key);
            end
        end
    endtask

    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (err_prev) begin
                total++;
                if (err !== 1'b0) begin
                    bad++;
                    $display("FAIL err_width got=%b required=0", err);
                end
            end
            if (err === 1'b1 && !err_prev) check_event(1'b1, ps2_key);
            if (ps2_key !== last_key) check_event(1'b0, ps2_key);
        end
        err_prev = mon_en ? err : 1'b0;
        last_key = ps2_key;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(2);
        total++;
        if (ps2_key !== 11'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got key=%h err=%b required key=000 err=0", ps2_key, err);
        end
        mon_en = 1'b1;

        // Reset in the middle of a frame: silent discard.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1 == 1'b0);
        @(negedge clk_sys) reset = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(H);
        total++;
        if (ps2_key !== 11'd0) begin
            bad++;
            $display("FAIL midframe_reset got=%h required=000", ps2_key);
        end

        push_key(11'h61C); send_frame(8'h1C);
        send_frame(8'hF0); wait_cyc(3 * H);
        push_key(11'h01C); send_frame(8'h1C);
        send_frame(8'hE0); push_key(11'h774); send_frame(8'h74);
        send_frame(8'hE0); send_frame(8'hF0); push_key(11'h174); send_frame(8'h74);
        push_key(11'h61C); send_frame(8'h1C);
        send_frame(8'hF0); push_key(11'h01C); send_frame(8'h1C);
        push_key(11'h61C); send_frame(8'h1C);
        send_frame(8'hFA);

        push_err(); send_frame(8'h1C, 1'b0);

        push_err();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(TMO + 4 * H);

        push_key(11'h21C); send_frame(8'h1C);

        send_frame(8'hE1); send_frame(8'h14); send_frame(8'h77);
        send_frame(8'hE1); send_frame(8'hF0); send_frame(8'h14);
        send_frame(8'hF0); send_frame(8'h77);
        push_key(11'h61C); send_frame(8'h1C);

        push_key(11'h21C); send_frame(8'h1C, 1'b1, 1'b0, 3);

`ifdef PS2_PARITY_CHECK_EN
        push_err();
`else
        push_key(11'h61C);
`endif
        send_frame(8'h1C, 1'b1, 1'b1);

        for (int i = 0; i < 500 && expq.size() != 0; i++) wait_cyc(1);
        wait_cyc(10);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL pending_events got=%0d required=0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Upstream keyboard front end. Receives raw PS/2 clock/data from the keyboard connector and deserialises 11-bit device-to-host frames. Folds E0/F0 prefixes into one event and presents it on the 11-bit ps2_key bus that the keyboard matrix and the ZX81 core consume. Bit 10 is a toggle strobe, bit 9 is pressed, bit 8 is extended, bits 7:0 are the scancode.

Parameters:
FILTER_LEN, 8, consecutive equal clk_sys samples required before the filtered PS/2 line changes (range 2..255).
TIMEOUT_CYCLES, 50000, clk_sys cycles without a filtered ps2_clk falling edge before a partial frame is abandoned (about 2 ms at 25 MHz).

Ports:
clk_sys  input  1  system clock; the only clock in the block
reset  input  1  synchronous reset, active-low
ps2_clk  input  1  raw PS/2 clock line, asynchronous, idles high
ps2_data  input  1  raw PS/2 data line, asynchronous, idles high
ps2_key  output  11  {toggle, pressed, extended, scancode[7:0]}
err  output  1  one-cycle pulse on any discarded frame

Behaviour:
- Reset (reset==0 sampled on a clk_sys edge):
  - ps2_key=0 and err=0.
  - FSM goes to IDLE; ext/rel flags clear; skip counter=0; timeout counter=0; bit counter=0.
  - Filter outputs go to 1, and filter run counters clear.
  - A reset mid-frame discards the frame silently, with no err pulse.
- Input conditioning:
  - Each line passes a 2-FF synchroniser, then the filter.
  - The filtered output takes the synchronised value only after FILTER_LEN consecutive identical samples.
- Falling edge: cycle where the filtered clock goes 1 to 0. The filtered data bit is sampled in that cycle.
- Frame FSM, one state advance per falling edge:
  - IDLE: data=0 goes to DATA with bit count=0. data=1 is ignored and stays in IDLE, with no err.
  - DATA: shift data into shreg LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: data=1 means the frame is good and goes to PROCESS. data=0 pulses err and goes to IDLE.
  - PROCESS: lasts exactly one clk_sys cycle, then goes to IDLE.
- Timeout:
  - The counter runs in any state other than IDLE and clears on every falling edge.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE and err pulses.
  - If an edge and the terminal count occur in the same cycle, the edge wins.
- PROCESS byte handling, in priority order:
  1. Skip counter nonzero: decrement it and emit nothing.
  2. 8'hE1: skip=7 (swallows the rest of the Pause sequence). Emit nothing.
  3. 8'hE0: ext=1.
  4. 8'hF0: rel=1.
  5. 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: clear ext and rel, emit nothing.
  6. Any other byte: ps2_key <= {~ps2_key[10], ~rel, ext, byte}, then clear ext and rel.
- Timing:
  - ps2_key updates on the clk_sys edge ending the PROCESS cycle, which is 2 cycles after the stop-bit edge cycle.
  - ps2_key holds until the next event.
  - err pulses exactly 1 cycle and always goes high together with the FSM entering IDLE.
- Any discarded frame also clears ext, rel and skip, so a lost byte cannot corrupt the next event.
- Consumers detect a new event by a change in bit 10. Consecutive identical keys must still flip bit 10.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: in STOP, a good stop bit combined with odd parity failing (^{parity, shreg} != 1) is treated as an error. The frame is discarded, err pulses and the flags clear.
- Undefined: the parity bit is captured but ignored. No parity logic remains in the netlist beyond the capture flop.

Decomposition:
- Package ps2_pkg holds:
  - the state enum {IDLE, DATA, PARITY, STOP, PROCESS};
  - constants PS2_PFX_EXT=8'hE0, PS2_PFX_REL=8'hF0, PS2_PFX_PAUSE=8'hE1, PS2_PAUSE_SKIP=7;
  - the ignore-list constants (AA, FA, EE, FE, 00, FF);
  - bit-index constants KEY_TOGGLE=10, KEY_PRESSED=9, KEY_EXT=8.
- Sub-module ps2_line_filter (synchroniser plus FILTER_LEN run filter) is instantiated twice: once for clk, once for data.

Test Plan:
- Reset, then frame 8'h1C (good parity/stop) -> ps2_key=11'h61C two cycles after the stop edge; err stays 0.
- After that, frames F0,1C -> ps2_key=11'h01C; F0 alone produces no update.
- Frames E0,74 then E0,F0,74 -> ps2_key=11'h774 then 11'h174. Then 1C,F0,1C,1C -> bit 10 flips on every emitted event, including the repeated 1C.
- Frame with stop bit=0 -> err pulse of 1 cycle, ps2_key unchanged. Then 5 bits followed by a stall of TIMEOUT_CYCLES -> err pulse, FSM in IDLE. A following good 8'h1C decodes normally.
- Pause sequence E1,14,77,E1,F0,14,F0,77, then 1C -> the first 8 bytes leave ps2_key unchanged; 1C then toggles bit 10. ps2_clk glitch low for FILTER_LEN-1 cycles mid-frame -> no extra bit shifted.
- With PS2_PARITY_CHECK_EN: 8'h1C with the parity bit inverted -> err pulse, no update. Without the macro, the same stimulus -> ps2_key updates normally.
